// File: rtl/prod_acc_pkg.sv
//============================================================================
// Module  : prod_acc_pkg
// Brief   : Shared types and constants for the product accumulator.
// Revision: 1.0  initial release
//============================================================================
`default_nettype none

package prod_acc_pkg;

  localparam int PROD_W            = 8;
  localparam int DEFAULT_ACC_W     = 16;
  localparam int DEFAULT_MAX_TERMS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/acc_add.sv
//============================================================================
// Module  : acc_add
// Brief   : ACC_W-bit accumulate adder with carry-out; clamps to all-ones
//           on carry when PROD_ACC_SATURATE_EN is defined, else wraps.
// Revision: 1.0  initial release
//============================================================================
`default_nettype none

import prod_acc_pkg::*;

module acc_add #(
  parameter int ACC_W = DEFAULT_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

`ifdef PROD_ACC_SATURATE_EN
  localparam bit c_sat = 1'b1;
`else
  localparam bit c_sat = 1'b0;
`endif

  logic [ACC_W:0] w_wide;

  assign w_wide = {1'b0, acc} + (ACC_W+1)'(prod);
  assign carry  = w_wide[ACC_W];

  // Once clamped, any further add either carries again or adds zero,
  // so the accumulator stays pinned at all-ones for the rest of the group.
  generate
    if (c_sat) begin : g_sat
      assign sum = w_wide[ACC_W] ? {ACC_W{1'b1}} : w_wide[ACC_W-1:0];
    end else begin : g_wrap
      assign sum = w_wide[ACC_W-1:0];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/prod_accumulator.sv
//============================================================================
// Module  : prod_accumulator
// Brief   : Sums groups of 8-bit products under valid/ready in and out.
//           Optional macro PROD_ACC_SATURATE_EN selects clamping on overflow.
// Revision: 1.0  initial release
//============================================================================
`default_nettype none

import prod_acc_pkg::*;

module prod_accumulator #(
  parameter int ACC_W     = DEFAULT_ACC_W,
  parameter int MAX_TERMS = DEFAULT_MAX_TERMS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        prod_in,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [7:0]        term_cnt,
  output logic              ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [7:0] c_max_terms = 8'(MAX_TERMS);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [7:0]         r_cnt;
  logic               r_ovf;
  logic [7:0]         w_cnt_inc;
  logic [ACC_W-1:0]   w_sum;
  logic               w_carry;
  logic               w_beat;
  logic               w_load;
  logic               w_accum;
  logic               w_in_ready;

  // Ready comes from the state register alone: no path from in_valid.
  assign w_in_ready = (r_state != DONE);
  assign w_beat     = in_valid && w_in_ready;
  assign w_cnt_inc  = r_cnt + 8'd1;

  acc_add #(
    .ACC_W (ACC_W)
  ) u_acc_add (
    .acc   (r_acc),
    .prod  (prod_in),
    .sum   (w_sum),
    .carry (w_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_accum     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_beat) begin
          w_load      = 1'b1;
          w_state_nxt = (in_last || (c_max_terms == 8'd1)) ? DONE : ACC;
        end
      end
      ACC: begin
        if (w_beat) begin
          w_accum     = 1'b1;
          w_state_nxt = (in_last || (w_cnt_inc == c_max_terms)) ? DONE : ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The first beat of a group loads rather than adds, so results survive
  // in IDLE until the next group actually starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= 8'd0;
      r_ovf <= 1'b0;
    end else if (w_load) begin
      r_acc <= ACC_W'(prod_in);
      r_cnt <= 8'd1;
      r_ovf <= 1'b0;
    end else if (w_accum) begin
      r_acc <= w_sum;
      r_cnt <= w_cnt_inc;
      r_ovf <= r_ovf | w_carry;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == DONE);
  assign acc_out   = r_acc;
  assign term_cnt  = r_cnt;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire
